// File: rtl/crc_stream_engine.sv
// crc_stream_engine: streaming CRC generator/checker
// Folds BPC bits per clock of each accepted beat into a CRC_W LFSR.
module crc_stream_engine #(
    parameter int               CRC_W  = 32,
    parameter int               DATA_W = 32,
    parameter int               BPC    = 1,
    parameter logic [CRC_W-1:0] INIT   = {CRC_W{1'b1}},
    parameter logic [CRC_W-1:0] XOROUT = {CRC_W{1'b1}},
    parameter bit               REFIN  = 1'b0,
    parameter bit               REFOUT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CRC_W:0]    poly_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [CRC_W-1:0]  crc_exp_i,
    output logic [CRC_W-1:0]  crc_o,
    output logic              crc_valid,
    output logic              ok_o,
    output logic              busy
);

    localparam int STEPS = DATA_W / BPC;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT,
        S_FINAL
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CRC_W-1:0]   lfsr_q;
    logic [CRC_W-1:0]   lfsr_step;
    logic [CRC_W-1:0]   poly_q;
    logic [DATA_W-1:0]  shreg_q;
    logic               last_q;
    logic [CRC_W-1:0]   exp_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CRC_W-1:0]   crc_q;
    logic               ok_q;
    logic               valid_q;
    logic [CRC_W-1:0]   final_crc;
    logic               xfer;
    logic               in_shift;
    logic               in_final;
    logic               shift_done;
    logic               unused_poly_top;

    function automatic logic [DATA_W-1:0] rev_d(
        input logic [DATA_W-1:0] x
    );
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = x[DATA_W-1-i];
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] rev_c(
        input logic [CRC_W-1:0] x
    );
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = x[CRC_W-1-i];
        end
        return r;
    endfunction

    // The top polynomial term is implied, so the MSB of poly_i is never used.
    assign unused_poly_top = poly_i[CRC_W];

    assign xfer       = in_valid & in_ready;
    assign in_shift   = (state_q == S_SHIFT);
    assign in_final   = (state_q == S_FINAL);
    assign shift_done = in_shift && (cnt_q == CNT_W'(STEPS - 1));
    assign in_ready   = (state_q == S_IDLE) || (state_q == S_WAIT);
    assign busy       = (state_q != S_IDLE);
    assign crc_o      = crc_q;
    assign ok_o       = ok_q;
    assign crc_valid  = valid_q;

    assign final_crc = (REFOUT ? rev_c(lfsr_q) : lfsr_q) ^ XOROUT;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a beat shifts for STEPS cycles, then waits or finalises.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (xfer) state_d = S_SHIFT;
            S_SHIFT: if (shift_done) state_d = last_q ? S_FINAL : S_WAIT;
            S_WAIT:  if (xfer) state_d = S_SHIFT;
            S_FINAL: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Unrolled BPC-bit LFSR step, taking beat bits from the top of shreg.
    always_comb begin
        logic fb;
        fb        = 1'b0;
        lfsr_step = lfsr_q;
        for (int i = 0; i < BPC; i++) begin
            fb        = lfsr_step[CRC_W-1] ^ shreg_q[DATA_W-1-i];
            lfsr_step = {lfsr_step[CRC_W-2:0], 1'b0}
                      ^ (fb ? poly_q : '0);
        end
    end

    // Datapath: latch beats, advance the LFSR, publish the final result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q  <= INIT;
            poly_q  <= '0;
            shreg_q <= '0;
            last_q  <= 1'b0;
            exp_q   <= '0;
            cnt_q   <= '0;
            crc_q   <= '0;
            ok_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (1'b1)
                xfer: begin
                    shreg_q <= REFIN ? rev_d(in_data) : in_data;
                    last_q  <= in_last;
                    exp_q   <= crc_exp_i;
                    cnt_q   <= '0;
                    if (state_q == S_IDLE) begin
                        lfsr_q <= INIT;
                        poly_q <= poly_i[CRC_W-1:0];
                    end
                end
                in_shift: begin
                    lfsr_q  <= lfsr_step;
                    shreg_q <= shreg_q << BPC;
                    cnt_q   <= cnt_q + CNT_W'(1);
                end
                in_final: begin
                    crc_q   <= final_crc;
                    ok_q    <= (final_crc == exp_q);
                    valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
